// File: rtl/input_controller.sv
// input_controller: panel buttons/switches -> CONV_U/CK_PERM command bus for output_controller.
// Optional macro ROUND_ROBIN_EN selects rotating arbitration; default is fixed lowest-index priority.
module input_controller #(
    parameter int DEB_CYCLES  = 4,
    parameter int HOLD_CYCLES = 8
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [2:0] REQ_IN,
    input  logic       DEST_SW,
    input  logic       ALL_SW,
    output logic [1:0] CONV_U,
    output logic [2:0] CK_PERM,
    output logic       BUSY
);

    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_GRANT, S_HOLD, S_ALL} state_t;

    // Raw input bundle: [2:0] requests, [3] destination, [4] all-channels override.
    logic [4:0]    raw, sync_a, sync_b, deb;
    logic [DW-1:0] deb_cnt [5];

    assign raw = {ALL_SW, DEST_SW, REQ_IN};

    // NOTE: sequential state uses <= so every flop samples the values from before the edge.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= raw;
            sync_b <= sync_a;
        end
    end

    // NOTE: the counter array is control state, so every element gets an explicit reset value.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < 5; i++) deb_cnt[i] <= '0;
            deb <= '0;
        end else begin
            for (int i = 0; i < 5; i++) begin
                if (sync_b[i] == deb[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_LAST) begin
                    deb_cnt[i] <= '0;
                    deb[i]     <= sync_b[i];
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + DW'(1);
                end
            end
        end
    end

    logic       deb_dest, deb_all;
    logic [2:0] req_q, req_rise, pending, grant_clr;
    logic       flush;
    logic [1:0] win;
    logic [2:0] win_oh;

    assign deb_dest = deb[3];
    assign deb_all  = deb[4];
    assign req_rise = deb[2:0] & ~req_q;
    assign win_oh   = 3'b001 << win;

    state_t          state, state_nxt;
    logic [HW-1:0]   hold_cnt, hold_nxt;
    logic [2:0]      perm_nxt;
    logic [1:0]      conv_nxt;
    logic            busy_nxt;

`ifdef ROUND_ROBIN_EN
    logic [1:0] rr_ptr;

    function automatic logic [1:0] wrap3(input logic [1:0] base, input logic [1:0] off);
        logic [2:0] s;
        s = {1'b0, base} + {1'b0, off};
        return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
    endfunction

    // Scan from the farthest offset down so the nearest pending channel after rr_ptr wins.
    always_comb begin
        win = rr_ptr;
        for (int k = 2; k >= 0; k--) begin
            if (pending[wrap3(rr_ptr, 2'(k))]) win = wrap3(rr_ptr, 2'(k));
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)                         rr_ptr <= '0;
        else if (state == S_GRANT && !deb_all) rr_ptr <= wrap3(win, 2'd1);
    end
`else
    always_comb begin
        if (pending[0])      win = 2'd0;
        else if (pending[1]) win = 2'd1;
        else                 win = 2'd2;
    end
`endif

    // Set wins over a same-cycle grant clear or override flush.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            req_q   <= '0;
            pending <= '0;
        end else begin
            req_q   <= deb[2:0];
            pending <= (flush ? 3'b000 : (pending & ~grant_clr)) | req_rise;
        end
    end

    // NOTE: every output of this block is given a default first, so no path infers a latch.
    always_comb begin
        state_nxt = state;
        perm_nxt  = CK_PERM;
        conv_nxt  = CONV_U;
        busy_nxt  = BUSY;
        hold_nxt  = hold_cnt;
        grant_clr = '0;
        flush     = 1'b0;
        case (state)
            S_IDLE: begin
                perm_nxt = '0;
                conv_nxt = {deb_dest, 1'b0};
                busy_nxt = 1'b0;
                if (|pending) state_nxt = S_GRANT;
            end
            S_GRANT: begin
                if (!deb_all) begin
                    perm_nxt  = win_oh;
                    conv_nxt  = {deb_dest, 1'b0};
                    busy_nxt  = 1'b1;
                    grant_clr = win_oh;
                    hold_nxt  = HOLD_LAST;
                    state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (hold_cnt == '0) state_nxt = S_IDLE;
                else                hold_nxt  = hold_cnt - HW'(1);
            end
            S_ALL: begin
                perm_nxt = 3'b111;
                conv_nxt = {deb_dest, 1'b1};
                busy_nxt = 1'b1;
                if (!deb_all) begin
                    state_nxt = S_IDLE;
                    flush     = 1'b1;
                end
            end
        endcase
        // The override pre-empts whatever the current state decided.
        if (deb_all) state_nxt = S_ALL;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= S_IDLE;
            hold_cnt <= '0;
            CK_PERM  <= '0;
            CONV_U   <= '0;
            BUSY     <= 1'b0;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_nxt;
            CK_PERM  <= perm_nxt;
            CONV_U   <= conv_nxt;
            BUSY     <= busy_nxt;
        end
    end

endmodule
